// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin IFU/LSU arbiter and single-access sequencer for the shared memory block
//
// Ports:
//   clk, rst                    rising-edge clock, asynchronous active-high reset
//   ifu_req_*, ifu_addr         IFU read request handshake and address
//   ifu_resp_*, ifu_rdata       IFU response handshake and read data
//   lsu_req_*, lsu_wr/addr/...  LSU request handshake and read/write payload
//   lsu_resp_*, lsu_rdata       LSU response handshake and read data (0 on write ack)
//   mem_en/rd/addr/wdata/wstrb  memory access port, mem_en pulses for one cycle per access
//   mem_rdata                   memory read data, combinational from mem_addr
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wr,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wstrb,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_en,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic       OWN_IFU   = 1'b0;
    localparam logic       OWN_LSU   = 1'b1;
    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [DATA_W-1:0] resp_q, resp_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              grant_ifu, grant_lsu;
    logic              resp_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= OWN_LSU;
            owner_q      <= OWN_IFU;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            resp_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            resp_q       <= resp_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        resp_d       = resp_q;
        cnt_d        = cnt_q;
        grant_ifu    = 1'b0;
        grant_lsu    = 1'b0;
        resp_hs      = 1'b0;

        case (state_q)
            IDLE: begin
                // IFU wins a tie only when the LSU was served last.
                grant_ifu = ifu_req_valid && (!lsu_req_valid || (last_grant_q == OWN_LSU));
                grant_lsu = lsu_req_valid && !grant_ifu;
                if (grant_ifu) begin
                    owner_d      = OWN_IFU;
                    last_grant_d = OWN_IFU;
                    wr_d         = 1'b0;
                    addr_d       = ifu_addr;
                    wdata_d      = '0;
                    wstrb_d      = '0;
                    state_d      = ACCESS;
                end else if (grant_lsu) begin
                    owner_d      = OWN_LSU;
                    last_grant_d = OWN_LSU;
                    wr_d         = lsu_wr;
                    addr_d       = lsu_addr;
                    wdata_d      = lsu_wdata;
                    wstrb_d      = lsu_wstrb;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                // Memory data is combinational, so the read completes on this edge.
                resp_d  = wr_q ? '0 : mem_rdata;
                cnt_d   = WAIT_LOAD;
                state_d = (LATENCY > 1) ? WAIT : RESP;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_hs = (owner_q == OWN_LSU) ? lsu_resp_ready : ifu_resp_ready;
                if (resp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ifu_req_ready  = grant_ifu;
    assign lsu_req_ready  = grant_lsu;
    assign ifu_resp_valid = (state_q == RESP) && (owner_q == OWN_IFU);
    assign lsu_resp_valid = (state_q == RESP) && (owner_q == OWN_LSU);
    assign ifu_rdata      = resp_q;
    assign lsu_rdata      = resp_q;

    // Decoded from the state register so an asynchronous reset drops the strobe at once.
    assign mem_en    = (state_q == ACCESS);
    assign mem_rd    = ~wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter at LATENCY 1 and 3
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ifu_req_valid = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        ifu_resp_ready = 1'b0;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_wr = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wstrb = '0;
    logic        lsu_resp_ready = 1'b0;

    logic        u1_ifu_req_ready, u1_ifu_resp_valid, u1_lsu_req_ready, u1_lsu_resp_valid;
    logic        u1_mem_en, u1_mem_rd;
    logic [31:0] u1_ifu_rdata, u1_lsu_rdata, u1_mem_addr, u1_mem_wdata, u1_mem_rdata;
    logic [3:0]  u1_mem_wstrb;
    logic        u3_ifu_req_ready, u3_ifu_resp_valid, u3_lsu_req_ready, u3_lsu_resp_valid;
    logic        u3_mem_en, u3_mem_rd;
    logic [31:0] u3_ifu_rdata, u3_lsu_rdata, u3_mem_addr, u3_mem_wdata, u3_mem_rdata;
    logic [3:0]  u3_mem_wstrb;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : ((a ^ 32'h5A5A_0000) + 32'h1);
    endfunction

    assign u1_mem_rdata = mem_model(u1_mem_addr);
    assign u3_mem_rdata = mem_model(u3_mem_addr);

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(u1_ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(u1_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(u1_ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(u1_lsu_req_ready), .lsu_wr(lsu_wr),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_resp_valid(u1_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(u1_lsu_rdata),
        .mem_en(u1_mem_en), .mem_rd(u1_mem_rd), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
        .mem_wstrb(u1_mem_wstrb), .mem_rdata(u1_mem_rdata)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(3)) u3 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(u3_ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(u3_ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(u3_ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(u3_lsu_req_ready), .lsu_wr(lsu_wr),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_resp_valid(u3_lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(u3_lsu_rdata),
        .mem_en(u3_mem_en), .mem_rd(u3_mem_rd), .mem_addr(u3_mem_addr), .mem_wdata(u3_mem_wdata),
        .mem_wstrb(u3_mem_wstrb), .mem_rdata(u3_mem_rdata)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [6:0] rr_ifu_rdy = 7'b1000001;
    logic [6:0] rr_lsu_rdy = 7'b0001000;
    logic [6:0] rr_mem_en  = 7'b0010010;
    logic [6:0] rr_ifu_rv  = 7'b0000100;
    logic [6:0] rr_lsu_rv  = 7'b0100000;
    logic [9:0] bp_mem_en  = 10'b0000000010;
    logic [9:0] bp_lsu_rv  = 10'b0111110000;
    logic [9:0] bp_ifu_rdy = 10'b1000000000;
    logic [9:0] bp_lsu_rdy = 10'b0000000001;
    logic [4:0] l3_ifu_rv  = 5'b10000;

    initial begin
        // Reset state, before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk1("rst_mem_en", u1_mem_en, 1'b0);
        chk1("rst_mem_rd", u1_mem_rd, 1'b1);
        chk1("rst_ifu_rv", u1_ifu_resp_valid, 1'b0);
        chk1("rst_lsu_rv", u1_lsu_resp_valid, 1'b0);
        chk32("rst_mem_addr", u1_mem_addr, 32'h0);

        // IFU read with LATENCY 1.
        tick();
        rst = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0000;
        ifu_resp_ready = 1'b1;
        #1;
        chk1("l1_rd_c0_ifu_rdy", u1_ifu_req_ready, 1'b1);
        chk1("l1_rd_c0_lsu_rdy", u1_lsu_req_ready, 1'b0);
        chk1("l1_rd_c0_mem_en", u1_mem_en, 1'b0);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk1("l1_rd_c1_mem_en", u1_mem_en, 1'b1);
        chk1("l1_rd_c1_mem_rd", u1_mem_rd, 1'b1);
        chk32("l1_rd_c1_mem_addr", u1_mem_addr, 32'h8000_0000);
        tick();
        #1;
        chk1("l1_rd_c2_mem_en", u1_mem_en, 1'b0);
        chk1("l1_rd_c2_ifu_rv", u1_ifu_resp_valid, 1'b1);
        chk1("l1_rd_c2_lsu_rv", u1_lsu_resp_valid, 1'b0);
        chk32("l1_rd_c2_ifu_rdata", u1_ifu_rdata, 32'h0000_0413);
        tick();
        #1;
        chk1("l1_rd_c3_ifu_rv", u1_ifu_resp_valid, 1'b0);

        // Asynchronous reset in the middle of an ACCESS cycle.
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0004;
        tick();
        #1;
        chk1("arst_access_mem_en", u1_mem_en, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk1("arst_mem_en", u1_mem_en, 1'b0);
        chk1("arst_mem_rd", u1_mem_rd, 1'b1);
        chk1("arst_ifu_rv", u1_ifu_resp_valid, 1'b0);
        chk1("arst_lsu_rv", u1_lsu_resp_valid, 1'b0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk1("arst_release_ifu_rdy", u1_ifu_req_ready, 1'b1);
        ifu_req_valid = 1'b0;
        tick();
        #1;
        chk1("arst_after_ifu_rv", u1_ifu_resp_valid, 1'b0);

        // Round-robin with both requesters held valid for three grants.
        ifu_addr = 32'h8000_0008;
        lsu_addr = 32'h8000_2000;
        lsu_wr = 1'b0;
        lsu_resp_ready = 1'b1;
        tick();
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk1($sformatf("rr_c%0d_ifu_rdy", i), u1_ifu_req_ready, rr_ifu_rdy[i]);
            chk1($sformatf("rr_c%0d_lsu_rdy", i), u1_lsu_req_ready, rr_lsu_rdy[i]);
            chk1($sformatf("rr_c%0d_mem_en", i), u1_mem_en, rr_mem_en[i]);
            chk1($sformatf("rr_c%0d_ifu_rv", i), u1_ifu_resp_valid, rr_ifu_rv[i]);
            chk1($sformatf("rr_c%0d_lsu_rv", i), u1_lsu_resp_valid, rr_lsu_rv[i]);
            if (i == 1) chk32("rr_c1_mem_addr", u1_mem_addr, 32'h8000_0008);
            if (i == 4) chk32("rr_c4_mem_addr", u1_mem_addr, 32'h8000_2000);
            if (i == 2) chk32("rr_c2_ifu_rdata", u1_ifu_rdata, mem_model(32'h8000_0008));
            if (i == 5) chk32("rr_c5_lsu_rdata", u1_lsu_rdata, mem_model(32'h8000_2000));
            tick();
        end
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        tick();
        tick();

        // LSU write: one strobe, then a zero-data acknowledgement.
        lsu_req_valid = 1'b1;
        lsu_wr = 1'b1;
        lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF;
        lsu_wstrb = 4'b0011;
        #1;
        chk1("wr_c0_lsu_rdy", u1_lsu_req_ready, 1'b1);
        tick();
        lsu_req_valid = 1'b0;
        #1;
        chk1("wr_c1_mem_en", u1_mem_en, 1'b1);
        chk1("wr_c1_mem_rd", u1_mem_rd, 1'b0);
        chk32("wr_c1_mem_addr", u1_mem_addr, 32'h8000_1000);
        chk32("wr_c1_mem_wdata", u1_mem_wdata, 32'hDEAD_BEEF);
        chk32("wr_c1_mem_wstrb", {28'h0, u1_mem_wstrb}, 32'h3);
        tick();
        #1;
        chk1("wr_c2_mem_en", u1_mem_en, 1'b0);
        chk1("wr_c2_lsu_rv", u1_lsu_resp_valid, 1'b1);
        chk32("wr_c2_lsu_rdata", u1_lsu_rdata, 32'h0);
        tick();
        #1;
        chk1("wr_c3_lsu_rv", u1_lsu_resp_valid, 1'b0);
        chk1("wr_c3_mem_en", u1_mem_en, 1'b0);

        // Backpressure with LATENCY 3 and an IFU request pending behind it.
        #3 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        lsu_wr = 1'b0;
        lsu_resp_ready = 1'b0;
        ifu_resp_ready = 1'b0;
        tick();
        lsu_req_valid = 1'b1;
        lsu_addr = 32'h8000_3000;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) begin
                lsu_req_valid = 1'b0;
                ifu_req_valid = 1'b1;
                ifu_addr = 32'h8000_000C;
            end
            if (i == 8) lsu_resp_ready = 1'b1;
            #1;
            chk1($sformatf("bp_c%0d_mem_en", i), u3_mem_en, bp_mem_en[i]);
            chk1($sformatf("bp_c%0d_lsu_rv", i), u3_lsu_resp_valid, bp_lsu_rv[i]);
            chk1($sformatf("bp_c%0d_ifu_rdy", i), u3_ifu_req_ready, bp_ifu_rdy[i]);
            chk1($sformatf("bp_c%0d_lsu_rdy", i), u3_lsu_req_ready, bp_lsu_rdy[i]);
            if (bp_lsu_rv[i]) chk32($sformatf("bp_c%0d_lsu_rdata", i), u3_lsu_rdata, mem_model(32'h8000_3000));
            tick();
        end
        ifu_req_valid = 1'b0;
        ifu_resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1($sformatf("bp_ifu_c%0d_rv", i + 10), u3_ifu_resp_valid, (i == 3));
            if (i == 3) chk32("bp_ifu_c13_rdata", u3_ifu_rdata, mem_model(32'h8000_000C));
            tick();
        end

        // Reset while waiting with LATENCY 3, then a normal read.
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0010;
        #1;
        chk1("rw_c0_ifu_rdy", u3_ifu_req_ready, 1'b1);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk1("rw_c1_mem_en", u3_mem_en, 1'b1);
        tick();
        #1;
        chk1("rw_c2_mem_en", u3_mem_en, 1'b0);
        chk1("rw_c2_ifu_rv", u3_ifu_resp_valid, 1'b0);
        #3 rst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) rst = 1'b0;
            #1;
            chk1($sformatf("rw_quiet%0d_ifu_rv", i), u3_ifu_resp_valid, 1'b0);
            chk1($sformatf("rw_quiet%0d_mem_en", i), u3_mem_en, 1'b0);
            tick();
        end
        ifu_req_valid = 1'b1;
        ifu_addr = 32'h8000_0014;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (i == 0) chk1("rw_new_c0_ifu_rdy", u3_ifu_req_ready, 1'b1);
            chk1($sformatf("rw_new_c%0d_ifu_rv", i), u3_ifu_resp_valid, l3_ifu_rv[i]);
            if (i == 4) chk32("rw_new_c4_ifu_rdata", u3_ifu_rdata, mem_model(32'h8000_0014));
            tick();
            ifu_req_valid = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
